io_timer_device: RTL and testbench
==================================

# io_timer_device

Memory-mapped millisecond timer that responds to the IO-bus load/store accesses issued by the memory stage's IO address decoder. It sits beside the key/switch/LED/HEX devices on the `0xF0000000` IO page and owns three registers: TCNT (count), TLIM (limit) and TCTL (status). Loads read these registers combinationally. Stores update them on the clock edge. A free-running prescaler advances TCNT once per millisecond.

## Interface
- `DBITS`, 32, data/address width
- `ADDR_TCNT`, 32'hF0000020, count register address
- `ADDR_TLIM`, 32'hF0000024, limit register address
- `ADDR_TCTL`, 32'hF0000120, control/status register address
- `CLK_PER_MS`, 50000, clock cycles per TCNT increment (≥2)

Ports:
- `clk`  in  1  system clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `addr`  in  DBITS  byte address of current memory-stage access
- `dataIn`  in  DBITS  store data
- `wrtEn`  in  1  store strobe; qualified by address match
- `hit`  out  1  `addr` equals one of the three register addresses (combinational)
- `dataOut`  out  DBITS  read data for `addr`; 0 when `hit`=0 (combinational)
- `irq`  out  1  equals TCTL.ready

## Operation
Registers:
- TCNT: DBITS bits.
- TLIM: DBITS bits.
- TCTL: bit0 = ready, bit2 = overrun. All other bits read 0.

Prescaler:
- `pre` counts 0..CLK_PER_MS-1, then wraps to 0.
- `tick` = (`pre` == CLK_PER_MS-1).

On `tick`:
- If TLIM≠0 and TCNT == TLIM-1:
  - TCNT ← 0.
  - If ready is already 1, overrun ← 1.
  - ready ← 1.
- Otherwise TCNT ← TCNT+1. This wraps modulo 2^DBITS. ready is not set when TLIM=0.

Stores (`wrtEn`=1 and address match):
- TCNT ← `dataIn`; `pre` ← 0.
- TLIM ← `dataIn`; TCNT ← 0; `pre` ← 0.
- TCTL: ready ← ready & `dataIn`[0]; overrun ← overrun & `dataIn`[2]. Software can only clear these bits; writing 1 has no effect.

Reads:
- Return the current register value with unused bits zero.
- Have no side effects.

Unmatched addresses:
- Stores are ignored.
- `dataOut` = 0 and `hit` = 0.

## Timing
- Reset: TCNT=0, TLIM=0, ready=0, overrun=0, `pre`=0. Output values during and right after reset: `irq`=0; `dataOut`=0 for every address.
- Reset wins over all other events in the same cycle.
- Store latency: the register updates on the edge where `wrtEn`=1. A read in the next cycle returns the new value.
- `hit` and `dataOut` have zero latency (combinational from `addr`). There is no handshake; every access completes in one cycle.
- TCNT/TLIM store in the same cycle as `tick`: the store wins. TCNT takes the stored value (or 0 for a TLIM store), and the tick is discarded.
- TCTL clear in the same cycle as a limit-reaching `tick`:
  - Set wins over clear; ready = 1 after the edge.
  - overrun ← 1 only if ready was 1 before the edge and the store did not clear ready.
- First tick after reset or after a prescaler-clearing store: CLK_PER_MS cycles later.
- Limit period: with TLIM=N, ready first asserts N·CLK_PER_MS cycles after the TLIM store edge.
- Changing TLIM mid-count restarts from 0. There is no partial-period carry.

## Test plan
All scenarios use CLK_PER_MS=4.

1. Reset, then read all three addresses.
   - Expected: `dataOut`=0 and `hit`=1 for each; `irq`=0.
   - Read 0xF0000028. Expected: `hit`=0, `dataOut`=0.
2. Free run with TLIM=0 for 40 cycles, then read TCNT.
   - Expected: TCNT=10; ready=0.
   - Store TCNT=0xFFFFFFFF, wait 4 cycles. Expected: TCNT=0.
3. Store TLIM=3.
   - Expected: `irq` rises exactly 12 cycles after the store edge; TCNT reads 0 that cycle.
   - Wait 12 more cycles. Expected: TCTL reads 0x5 (overrun set).
4. Store TCTL=0 while ready=1 and overrun=1.
   - Expected: TCTL reads 0 next cycle.
   - Store TCTL=0x5 when it is 0. Expected: TCTL stays 0.
5. Simultaneous events with TLIM=3:
   - Store TCTL=0 on the limit-reaching tick cycle. Expected: ready=1 and overrun=0 after the edge.
   - Store TCNT=7 on a tick cycle. Expected: TCNT reads 7, not 8 or 0.
6. Assert `reset` mid-count with TLIM=5 and TCNT=2.
   - Expected: next cycle all registers read 0.
   - After reset, TCNT increments only every 4 cycles and `irq` never asserts.

Source files
------------

// File: rtl/io_timer_device.sv
// io_timer_device: memory-mapped millisecond timer on the IO page.
// Three registers: TCNT (count), TLIM (limit), TCTL (ready/overrun status).
// Loads are combinational from addr; stores take effect on the clock edge.
// A free-running prescaler advances TCNT once every CLK_PER_MS cycles.
module io_timer_device #(
  parameter int          DBITS      = 32,
  parameter logic [31:0] ADDR_TCNT  = 32'hF0000020,
  parameter logic [31:0] ADDR_TLIM  = 32'hF0000024,
  parameter logic [31:0] ADDR_TCTL  = 32'hF0000120,
  parameter int          CLK_PER_MS = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] dataIn,
  input  logic             wrtEn,
  output logic             hit,
  output logic [DBITS-1:0] dataOut,
  output logic             irq
);

  // Prescaler width; at least one bit even for tiny CLK_PER_MS values.
  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0]    PRE_MAX = PW'(CLK_PER_MS - 1);
  localparam logic [PW-1:0]    PRE_ONE = PW'(1);
  localparam logic [DBITS-1:0] ONE     = DBITS'(1);

  logic [PW-1:0]    pre_reg,  pre_next;
  logic [DBITS-1:0] tcnt_reg, tcnt_next;
  logic [DBITS-1:0] tlim_reg, tlim_next;
  logic             ready_reg, ready_next;
  logic             overrun_reg, overrun_next;

  logic sel_tcnt, sel_tlim, sel_tctl;
  logic wr_tcnt, wr_tlim, wr_tctl;
  logic tick, limit_tick, limit_event;
  logic ready_kept, overrun_kept;

  // Address decode and qualified store strobes.
  always_comb begin
    sel_tcnt = (addr == DBITS'(ADDR_TCNT));
    sel_tlim = (addr == DBITS'(ADDR_TLIM));
    sel_tctl = (addr == DBITS'(ADDR_TCTL));
    hit      = sel_tcnt | sel_tlim | sel_tctl;
    wr_tcnt  = wrtEn & sel_tcnt;
    wr_tlim  = wrtEn & sel_tlim;
    wr_tctl  = wrtEn & sel_tctl;
  end

  // Next-state logic for prescaler, count, limit and status bits.
  always_comb begin
    tick       = (pre_reg == PRE_MAX);
    limit_tick = tick && (tlim_reg != '0) && (tcnt_reg == tlim_reg - ONE);
    // A TCNT or TLIM store discards a coincident tick, including its limit event.
    limit_event = limit_tick & ~wr_tcnt & ~wr_tlim;

    pre_next = tick ? '0 : pre_reg + PRE_ONE;
    if (wr_tcnt || wr_tlim) begin
      pre_next = '0;
    end

    tcnt_next = tcnt_reg;
    if (tick) begin
      tcnt_next = limit_tick ? '0 : tcnt_reg + ONE;
    end
    if (wr_tcnt) begin
      tcnt_next = dataIn;
    end else if (wr_tlim) begin
      tcnt_next = '0;
    end

    tlim_next = wr_tlim ? dataIn : tlim_reg;

    // Software may only clear status bits; writing 1 keeps the current value.
    ready_kept   = ready_reg   & (~wr_tctl | dataIn[0]);
    overrun_kept = overrun_reg & (~wr_tctl | dataIn[2]);

    // Limit event sets ready over a clear; overrun only if ready survived the store.
    ready_next   = limit_event | ready_kept;
    overrun_next = overrun_kept | (limit_event & ready_kept);
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_reg     <= '0;
      tcnt_reg    <= '0;
      tlim_reg    <= '0;
      ready_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      pre_reg     <= pre_next;
      tcnt_reg    <= tcnt_next;
      tlim_reg    <= tlim_next;
      ready_reg   <= ready_next;
      overrun_reg <= overrun_next;
    end
  end

  // Read mux: selected register with unused bits zero, zero on a miss.
  always_comb begin
    dataOut = '0;
    if (sel_tcnt) begin
      dataOut = tcnt_reg;
    end else if (sel_tlim) begin
      dataOut = tlim_reg;
    end else if (sel_tctl) begin
      dataOut[0] = ready_reg;
      dataOut[2] = overrun_reg;
    end
  end

  assign irq = ready_reg;

endmodule

// File: tb/tb_io_timer_device.sv
// Directed bench for io_timer_device with CLK_PER_MS=4.
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_io_timer_device;

  localparam logic [31:0] A_TCNT = 32'hF0000020;
  localparam logic [31:0] A_TLIM = 32'hF0000024;
  localparam logic [31:0] A_TCTL = 32'hF0000120;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] dataIn;
  logic        wrtEn;
  logic        hit;
  logic [31:0] dataOut;
  logic        irq;

  int total = 0;
  int bad   = 0;

  io_timer_device #(
    .DBITS(32), .ADDR_TCNT(A_TCNT), .ADDR_TLIM(A_TLIM),
    .ADDR_TCTL(A_TCTL), .CLK_PER_MS(4)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .dataIn(dataIn),
    .wrtEn(wrtEn), .hit(hit), .dataOut(dataOut), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        wr;
    logic        exp_hit;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end else begin
      $display("ok   %s got=%h", name, act);
    end
  endtask

  // Advance n full cycles, ending just after a falling edge.
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // One-cycle store that lands on the next rising edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; dataIn = d; wrtEn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wrtEn = 1'b0; dataIn = '0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a; wrtEn = 1'b0;
    #1;
    check(name, dataOut, exp);
  endtask

  initial begin
    reset = 1'b1; addr = '0; dataIn = '0; wrtEn = 1'b0;

    // Vectors applied while reset is held: decode is live, stores are overridden.
    vecs[0]  = '{A_TCNT,       32'h0,  1'b0, 1'b1, 32'h0};
    vecs[1]  = '{A_TLIM,       32'h0,  1'b0, 1'b1, 32'h0};
    vecs[2]  = '{A_TCTL,       32'h0,  1'b0, 1'b1, 32'h0};
    vecs[3]  = '{32'hF0000028, 32'h0,  1'b0, 1'b0, 32'h0};
    vecs[4]  = '{32'hF0000021, 32'h0,  1'b0, 1'b0, 32'h0};
    vecs[5]  = '{32'h00000020, 32'h0,  1'b0, 1'b0, 32'h0};
    vecs[6]  = '{32'hF0000124, 32'h0,  1'b0, 1'b0, 32'h0};
    vecs[7]  = '{A_TCNT,       32'h55, 1'b1, 1'b1, 32'h0};
    vecs[8]  = '{A_TCNT,       32'h0,  1'b0, 1'b1, 32'h0};
    vecs[9]  = '{A_TLIM,       32'h9,  1'b1, 1'b1, 32'h0};
    vecs[10] = '{A_TLIM,       32'h0,  1'b0, 1'b1, 32'h0};

    wait_cyc(2);
    for (int i = 0; i < 11; i++) begin
      addr = vecs[i].a; dataIn = vecs[i].d; wrtEn = vecs[i].wr;
      #1;
      check($sformatf("vec%0d_hit", i), {31'b0, hit}, {31'b0, vecs[i].exp_hit});
      check($sformatf("vec%0d_dout", i), dataOut, vecs[i].exp_dout);
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, 32'h0);
      @(posedge clk);
      @(negedge clk);
    end
    wrtEn = 1'b0;
    reset = 1'b0;

    // 1: post-reset reads.
    addr = A_TCNT; #1; check("t1_tcnt_hit", {31'b0, hit}, 32'h1); check("t1_tcnt", dataOut, 32'h0);
    addr = A_TLIM; #1; check("t1_tlim_hit", {31'b0, hit}, 32'h1); check("t1_tlim", dataOut, 32'h0);
    addr = A_TCTL; #1; check("t1_tctl_hit", {31'b0, hit}, 32'h1); check("t1_tctl", dataOut, 32'h0);
    check("t1_irq", {31'b0, irq}, 32'h0);
    addr = 32'hF0000028; #1; check("t1_miss_hit", {31'b0, hit}, 32'h0); check("t1_miss", dataOut, 32'h0);

    // 2: free run with TLIM=0; an unmatched store mid-run must be ignored.
    wait_cyc(20);
    store(32'hF0000028, 32'h5);
    wait_cyc(19);
    rd("t2_tcnt40", A_TCNT, 32'd10);
    rd("t2_tctl", A_TCTL, 32'h0);
    store(A_TCNT, 32'hFFFFFFFF);
    wait_cyc(3);
    rd("t2_tcnt_max", A_TCNT, 32'hFFFFFFFF);
    wait_cyc(1);
    rd("t2_tcnt_wrap", A_TCNT, 32'h0);
    rd("t2_tctl_wrap", A_TCTL, 32'h0);

    // 3: limit period of 3 ms = 12 cycles.
    store(A_TLIM, 32'd3);
    rd("t3_tlim", A_TLIM, 32'd3);
    rd("t3_tcnt0", A_TCNT, 32'd0);
    wait_cyc(11);
    check("t3_irq_c11", {31'b0, irq}, 32'h0);
    wait_cyc(1);
    check("t3_irq_c12", {31'b0, irq}, 32'h1);
    rd("t3_tcnt_c12", A_TCNT, 32'd0);
    wait_cyc(11);
    rd("t3_tctl_c23", A_TCTL, 32'h1);
    wait_cyc(1);
    rd("t3_tctl_c24", A_TCTL, 32'h5);

    // 4: software clear; writing ones does not set.
    store(A_TCTL, 32'h0);
    rd("t4_tctl_clr", A_TCTL, 32'h0);
    check("t4_irq_clr", {31'b0, irq}, 32'h0);
    store(A_TCTL, 32'h5);
    rd("t4_tctl_w1", A_TCTL, 32'h0);

    // 5: clear coincident with limit tick, then TCNT store on a tick.
    store(A_TLIM, 32'd3);
    wait_cyc(12);
    rd("t5_tctl_first", A_TCTL, 32'h1);
    wait_cyc(11);
    store(A_TCTL, 32'h0);
    rd("t5_tctl_setwins", A_TCTL, 32'h1);
    rd("t5_tcnt_lim", A_TCNT, 32'd0);
    wait_cyc(3);
    store(A_TCNT, 32'd7);
    rd("t5_tcnt_store", A_TCNT, 32'd7);
    wait_cyc(3);
    rd("t5_tcnt_hold", A_TCNT, 32'd7);
    wait_cyc(1);
    rd("t5_tcnt_next", A_TCNT, 32'd8);

    // 6: reset mid-count.
    store(A_TLIM, 32'd5);
    wait_cyc(8);
    rd("t6_tcnt_pre", A_TCNT, 32'd2);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    rd("t6_tcnt", A_TCNT, 32'd0);
    rd("t6_tlim", A_TLIM, 32'd0);
    rd("t6_tctl", A_TCTL, 32'd0);
    check("t6_irq", {31'b0, irq}, 32'h0);
    for (int i = 1; i <= 40; i++) begin
      wait_cyc(1);
      check($sformatf("t6_irq_c%0d", i), {31'b0, irq}, 32'h0);
      if (i == 3) rd("t6_tcnt_c3", A_TCNT, 32'd0);
      if (i == 4) rd("t6_tcnt_c4", A_TCNT, 32'd1);
    end
    rd("t6_tcnt_c40", A_TCNT, 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
